// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline hold request.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero status output.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         system_clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  input  logic         write_hi,
  input  logic         write_lo,
  input  logic [N-1:0] write_data,
  input  logic         read_hilo,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         hold_request
`ifdef DIV_ZERO_FLAG_EN
  , output logic       div_zero
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t          state, state_next;
  logic            is_div;
  logic            sign_a, sign_b, b_zero;
  logic [N-1:0]    mag_b, acc, mq;
  logic [CW-1:0]   counter;

  logic [N-1:0]    in_mag_a, in_mag_b;
  logic [N:0]      mul_sum;
  logic [N:0]      div_shift;
  logic            div_ge;
  logic [N-1:0]    div_diff;
  logic [2*N-1:0]  prod_fix;
  logic [N-1:0]    q_fix, r_fix;

  assign in_mag_a = (op[0] & operand_a[N-1]) ? -operand_a : operand_a;
  assign in_mag_b = (op[0] & operand_b[N-1]) ? -operand_b : operand_b;

  // Multiply: {acc,mq} shifts right, adding the multiplicand when the low multiplier bit is set.
  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mag_b} : {(N+1){1'b0}});
  // Divide: remainder in acc, dividend bits shift out of mq while quotient bits shift in.
  assign div_shift = {acc, mq[N-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_diff  = div_shift[N-1:0] - mag_b;

  assign prod_fix = (sign_a ^ sign_b) ? -{acc, mq} : {acc, mq};
  assign q_fix    = (sign_a ^ sign_b) ? -mq : mq;
  assign r_fix    = sign_a ? -acc : acc;

  assign busy         = (state != IDLE);
  assign hold_request = busy & (start | read_hilo | write_hi | write_lo);

  always_ff @(posedge system_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (counter == '0) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      acc     <= '0;
      mq      <= '0;
      mag_b   <= '0;
      is_div  <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            sign_a  <= op[0] & operand_a[N-1];
            sign_b  <= op[0] & operand_b[N-1];
            b_zero  <= (operand_b == '0);
            mq      <= in_mag_a;
            mag_b   <= in_mag_b;
            acc     <= '0;
            counter <= CW'(N - 1);
          end else begin
            if (write_hi) hi <= write_data;
            if (write_lo) lo <= write_data;
          end
        end
        RUN: begin
          if (counter != '0) counter <= counter - 1'b1;
          if (is_div) begin
            acc <= div_ge ? div_diff : div_shift[N-1:0];
            mq  <= {mq[N-2:0], div_ge};
          end else begin
            acc <= mul_sum[N:1];
            mq  <= {mul_sum[0], mq[N-1:1]};
          end
        end
        SIGN: begin
          // A zero divisor leaves |a| as remainder, so the dividend-sign fix-up restores operand_a.
          if (is_div) begin
            lo <= b_zero ? {N{1'b1}} : q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge system_clock) begin
    if (reset)                        div_zero <= 1'b0;
    else if (state == SIGN && is_div) div_zero <= b_zero;
  end
`endif

endmodule
